// File: rtl/aha_tlx_rev_tx.sv
// TLX reverse-channel transmitter: credit-gated payload launch from a 2-entry skid FIFO,
// link-training and heartbeat flow tokens. Define AHA_TLX_REV_TX_STATS_EN for beat/stall counters.
module aha_tlx_rev_tx #(
  parameter int unsigned PAYLOAD_W    = 80,
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned INIT_CREDITS = 4,
  parameter int unsigned MAX_CREDITS  = 8,
  parameter int unsigned TRAIN_COUNT  = 4,
  parameter int unsigned HB_PERIOD    = 64
) (
  input  logic                 TLX_REV_CLK,
  input  logic                 TLX_REV_RESETn,
  input  logic                 SRC_TVALID,
  output logic                 SRC_TREADY,
  input  logic [PAYLOAD_W-1:0] SRC_TDATA,
  output logic                 TLX_REV_PAYLOAD_TVALID,
  input  logic                 TLX_REV_PAYLOAD_TREADY,
  output logic [PAYLOAD_W-1:0] TLX_REV_PAYLOAD_TDATA,
  output logic                 TLX_REV_FLOW_TVALID,
  input  logic                 TLX_REV_FLOW_TREADY,
  output logic [2:0]           TLX_REV_FLOW_TDATA,
  input  logic                 TLX_CRD_TVALID,
  output logic                 TLX_CRD_TREADY,
  input  logic [1:0]           TLX_CRD_TDATA,
  output logic                 LINK_UP,
  output logic [CREDIT_W-1:0]  CREDIT_COUNT,
  output logic                 CREDIT_OVF
`ifdef AHA_TLX_REV_TX_STATS_EN
  ,
  output logic [31:0]          STAT_BEATS,
  output logic [31:0]          STAT_STALLS
`endif
);

  typedef enum logic [1:0] {StTrain, StDone, StActive} state_e;

  localparam logic [2:0]            TokTrain = 3'b010;
  localparam logic [2:0]            TokDone  = 3'b011;
  localparam logic [2:0]            TokHb    = 3'b001;
  localparam logic [CREDIT_W+1:0]   MaxCred  = (CREDIT_W+2)'(MAX_CREDITS);
  localparam logic [CREDIT_W-1:0]   InitCred = CREDIT_W'(INIT_CREDITS);
  localparam logic [15:0]           TrainCnt = 16'(TRAIN_COUNT);
  localparam logic                  HbEn     = (HB_PERIOD != 0);
  localparam logic [31:0]           HbLast   = (HB_PERIOD != 0) ? 32'(HB_PERIOD - 1) : 32'd0;

  state_e                state_q, state_d;
  logic [PAYLOAD_W-1:0]  fifo_mem [2];
  logic                  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  pay_vld_q, pay_vld_d;
  logic [PAYLOAD_W-1:0]  pay_dat_q, pay_dat_d;
  logic                  flow_vld_q, flow_vld_d;
  logic [2:0]            flow_dat_q, flow_dat_d;
  logic [15:0]           train_q, train_d;
  logic [31:0]           hb_q, hb_d;
  logic [CREDIT_W-1:0]   cred_q, cred_d;
  logic                  ovf_q, ovf_d;
  logic                  link_up_q, link_up_d;
  logic                  crd_rdy_q;

  logic                  src_hs, pay_hs, flow_hs, crd_hs;
  logic                  fifo_empty, head_vld, launch, push, pop, slot_free;
  logic [PAYLOAD_W-1:0]  head_dat;
  logic [CREDIT_W+1:0]   cred_sum;

  assign SRC_TREADY = (state_q == StActive) && (fifo_cnt_q != 2'd2);
  assign src_hs     = SRC_TVALID & SRC_TREADY;
  assign pay_hs     = pay_vld_q & TLX_REV_PAYLOAD_TREADY;
  assign flow_hs    = flow_vld_q & TLX_REV_FLOW_TREADY;
  assign crd_hs     = TLX_CRD_TVALID & crd_rdy_q;
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  // An empty FIFO lets the incoming word bypass straight into the output register.
  assign head_vld   = !fifo_empty || src_hs;
  assign head_dat   = fifo_empty ? SRC_TDATA : fifo_mem[fifo_rd_q];
  assign launch     = head_vld && (cred_q != '0) && (!pay_vld_q || TLX_REV_PAYLOAD_TREADY);
  assign push       = src_hs && !(launch && fifo_empty);
  assign pop        = launch && !fifo_empty;
  assign slot_free  = !flow_vld_q || flow_hs;

  always_comb begin
    state_d    = state_q;
    fifo_wr_d  = fifo_wr_q ^ push;
    fifo_rd_d  = fifo_rd_q ^ pop;
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
    pay_vld_d  = pay_vld_q;
    pay_dat_d  = pay_dat_q;
    flow_vld_d = flow_vld_q;
    flow_dat_d = flow_dat_q;
    train_d    = train_q;
    hb_d       = hb_q;
    cred_d     = cred_q;
    ovf_d      = ovf_q;
    link_up_d  = link_up_q;

    if (launch) begin
      pay_vld_d = 1'b1;
      pay_dat_d = head_dat;
    end else if (pay_hs) begin
      pay_vld_d = 1'b0;
    end

    cred_sum = {2'b00, cred_q} - (CREDIT_W+2)'(launch)
             + (CREDIT_W+2)'(crd_hs ? TLX_CRD_TDATA : 2'd0);
    if (cred_sum > MaxCred) begin
      cred_d = MaxCred[CREDIT_W-1:0];
      ovf_d  = 1'b1;
    end else begin
      cred_d = cred_sum[CREDIT_W-1:0];
    end

    if (flow_hs) flow_vld_d = 1'b0;
    unique case (state_q)
      StTrain: begin
        if (slot_free) begin
          train_d    = train_q + 16'(flow_hs);
          flow_vld_d = 1'b1;
          if (train_d == TrainCnt) begin
            flow_dat_d = TokDone;
            state_d    = StDone;
          end else begin
            flow_dat_d = TokTrain;
          end
        end
      end
      StDone: begin
        if (flow_hs) begin
          state_d   = StActive;
          link_up_d = 1'b1;
        end
      end
      StActive: begin
        if (HbEn && !flow_vld_q && (hb_q == HbLast)) begin
          flow_vld_d = 1'b1;
          flow_dat_d = TokHb;
        end
      end
      default: state_d = StTrain;
    endcase

    // Heartbeat counter saturates at its last value until the raised token is taken.
    if (!HbEn || (state_q != StActive) || pay_hs || flow_hs) begin
      hb_d = '0;
    end else if (hb_q != HbLast) begin
      hb_d = hb_q + 32'd1;
    end
  end

  always_ff @(posedge TLX_REV_CLK or negedge TLX_REV_RESETn) begin
    if (!TLX_REV_RESETn) begin
      state_q    <= StTrain;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      pay_vld_q  <= 1'b0;
      pay_dat_q  <= '0;
      flow_vld_q <= 1'b0;
      flow_dat_q <= 3'b000;
      train_q    <= '0;
      hb_q       <= '0;
      cred_q     <= InitCred;
      ovf_q      <= 1'b0;
      link_up_q  <= 1'b0;
      crd_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      pay_vld_q  <= pay_vld_d;
      pay_dat_q  <= pay_dat_d;
      flow_vld_q <= flow_vld_d;
      flow_dat_q <= flow_dat_d;
      train_q    <= train_d;
      hb_q       <= hb_d;
      cred_q     <= cred_d;
      ovf_q      <= ovf_d;
      link_up_q  <= link_up_d;
      crd_rdy_q  <= 1'b1;
    end
  end

  always_ff @(posedge TLX_REV_CLK) begin
    if (push) fifo_mem[fifo_wr_q] <= SRC_TDATA;
  end

  assign TLX_REV_PAYLOAD_TVALID = pay_vld_q;
  assign TLX_REV_PAYLOAD_TDATA  = pay_dat_q;
  assign TLX_REV_FLOW_TVALID    = flow_vld_q;
  assign TLX_REV_FLOW_TDATA     = flow_dat_q;
  assign TLX_CRD_TREADY         = crd_rdy_q;
  assign LINK_UP                = link_up_q;
  assign CREDIT_COUNT           = cred_q;
  assign CREDIT_OVF             = ovf_q;

`ifdef AHA_TLX_REV_TX_STATS_EN
  logic [31:0] beats_q, stalls_q;

  always_ff @(posedge TLX_REV_CLK or negedge TLX_REV_RESETn) begin
    if (!TLX_REV_RESETn) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pay_hs) beats_q <= beats_q + 32'd1;
      if (!fifo_empty && (cred_q == '0)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign STAT_BEATS  = beats_q;
  assign STAT_STALLS = stalls_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_aha_tlx_rev_tx.sv
// Scoreboard bench for aha_tlx_rev_tx: training, heartbeat, credit gating, stall hold,
// credit clamping and mid-operation reset.
module tb_aha_tlx_rev_tx;
  localparam int unsigned PW = 80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          src_vld, src_rdy;
  logic [PW-1:0] src_dat;
  logic          pay_vld, pay_rdy;
  logic [PW-1:0] pay_dat;
  logic          flow_vld, flow_rdy;
  logic [2:0]    flow_dat;
  logic          crd_vld, crd_rdy;
  logic [1:0]    crd_dat;
  logic          link_up, ovf;
  logic [3:0]    credit;
`ifdef AHA_TLX_REV_TX_STATS_EN
  logic [31:0]   stat_beats, stat_stalls;
`endif

  aha_tlx_rev_tx dut (
    .TLX_REV_CLK            (clk),
    .TLX_REV_RESETn         (rst_n),
    .SRC_TVALID             (src_vld),
    .SRC_TREADY             (src_rdy),
    .SRC_TDATA              (src_dat),
    .TLX_REV_PAYLOAD_TVALID (pay_vld),
    .TLX_REV_PAYLOAD_TREADY (pay_rdy),
    .TLX_REV_PAYLOAD_TDATA  (pay_dat),
    .TLX_REV_FLOW_TVALID    (flow_vld),
    .TLX_REV_FLOW_TREADY    (flow_rdy),
    .TLX_REV_FLOW_TDATA     (flow_dat),
    .TLX_CRD_TVALID         (crd_vld),
    .TLX_CRD_TREADY         (crd_rdy),
    .TLX_CRD_TDATA          (crd_dat),
    .LINK_UP                (link_up),
    .CREDIT_COUNT           (credit),
    .CREDIT_OVF             (ovf)
`ifdef AHA_TLX_REV_TX_STATS_EN
    ,
    .STAT_BEATS             (stat_beats),
    .STAT_STALLS            (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  int unsigned   beats   = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] word(input int i);
    logic [31:0] a;
    a = i;
    return {16'hC0DE, a * 32'h9E3779B9, a};
  endfunction

  // Payload scoreboard: every beat must match the oldest accepted source word.
  always @(negedge clk) begin
    if (rst_n && pay_vld && pay_rdy) begin
      beats++;
      if (exp_q.size() == 0) check_eq("pay_unexpected", 1, 0);
      else check_eq("pay_data", pay_dat, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [PW-1:0] w);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    src_vld = 1'b1;
    src_dat = w;
    while (!done && n < 50) begin
      @(negedge clk);
      if (src_rdy) begin
        exp_q.push_back(w);
        done = 1;
      end
      tick();
      n++;
    end
    src_vld = 1'b0;
    if (!done) check_eq("push_timeout", 0, 1);
  endtask

  task automatic credit_ret(input logic [1:0] n);
    crd_vld = 1'b1;
    crd_dat = n;
    tick();
    crd_vld = 1'b0;
    crd_dat = 2'd0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, early, unstable, b0;
    src_vld = 0; src_dat = '0; pay_rdy = 1; flow_rdy = 1; crd_vld = 0; crd_dat = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_flags", {pay_vld, flow_vld, src_rdy, crd_rdy, link_up, ovf}, 6'b0);
    check_eq("rst_credit", credit, 4);
    check_eq("rst_data", {flow_dat, pay_dat}, 0);
    rst_n = 1'b1;

    // Training: four TRAIN tokens then DONE on consecutive cycles.
    n = 0;
    @(negedge clk);
    while (!flow_vld && n < 10) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("train_tok%0d", i), {flow_vld, flow_dat},
               {1'b1, (i < 4) ? 3'b010 : 3'b011});
      if (link_up || src_rdy) bad++;
      @(negedge clk);
    end
    check_eq("train_lu_low", bad, 0);
    check_eq("link_up", {link_up, src_rdy, crd_rdy}, 3'b111);

    // Heartbeat: beat at A40 defers token to A105; hold with ready low; next after 64 idle.
    early = 0;
    unstable = 0;
    for (int i = 1; i <= 176; i++) begin
      @(posedge clk);
      #1;
      if (i == 39) begin src_vld = 1'b1; src_dat = word(100); end
      if (i == 40) src_vld = 1'b0;
      if (i == 100) flow_rdy = 1'b0;
      if (i == 111) flow_rdy = 1'b1;
      @(negedge clk);
      if (i == 39) begin
        check_eq("hb_src_rdy", src_rdy, 1);
        exp_q.push_back(word(100));
      end
      if (i == 40) check_eq("hb_pay_beat", pay_vld, 1);
      if ((i < 105 || (i >= 112 && i < 176)) && flow_vld) early++;
      if (i >= 105 && i <= 111 && {flow_vld, flow_dat} !== 4'b1001) unstable++;
      if (i == 176) check_eq("hb_idle64", {flow_vld, flow_dat}, 4'b1001);
    end
    check_eq("hb_early", early, 0);
    check_eq("hb_hold", unstable, 0);

    // Restore four credits, then push six words with no returns.
    tick();
    credit_ret(2'd1);
    b0 = beats;
    for (int i = 0; i < 6; i++) push_word(word(i));
    repeat (5) tick();
    @(negedge clk);
    check_eq("six_push_beats", beats - b0, 4);
    check_eq("six_push_credit", credit, 0);
    check_eq("six_push_full", {src_rdy, 32'(exp_q.size())}, {1'b0, 32'd2});

    // One credit beat of 2 releases the two buffered words on consecutive cycles.
    tick();
    crd_vld = 1'b1;
    crd_dat = 2'd2;
    @(negedge clk);
    check_eq("crd_ready", crd_rdy, 1);
    tick();
    crd_vld = 1'b0;
    crd_dat = 2'd0;
    @(negedge clk);
    check_eq("crd_not_same_cycle", pay_vld, 0);
    @(negedge clk);
    check_eq("crd_beat1", pay_vld, 1);
    @(negedge clk);
    check_eq("crd_beat2", pay_vld, 1);
    @(negedge clk);
    check_eq("crd_after", {pay_vld, src_rdy, credit, 32'(exp_q.size())}, {1'b0, 1'b1, 4'd0, 32'd0});

    // Back-pressure hold for 10 cycles, exactly one beat on release.
    tick();
    credit_ret(2'd3);
    pay_rdy = 1'b0;
    push_word(word(50));
    n = 0;
    @(negedge clk);
    while (!pay_vld && n < 10) begin
      @(negedge clk);
      n++;
    end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (!pay_vld || pay_dat !== word(50)) unstable++;
      @(negedge clk);
    end
    check_eq("hold_stable", unstable, 0);
    tick();
    b0 = beats;
    pay_rdy = 1'b1;
    repeat (3) tick();
    check_eq("hold_one_beat", beats - b0, 1);
    check_eq("hold_credit", credit, 2);

    // Clamp at MAX_CREDITS and sticky overflow.
    credit_ret(2'd3);
    credit_ret(2'd2);
    @(negedge clk);
    check_eq("cred_seven", {ovf, credit}, {1'b0, 4'd7});
    tick();
    credit_ret(2'd3);
    @(negedge clk);
    check_eq("cred_clamp", {ovf, credit}, {1'b1, 4'd8});
    repeat (5) tick();
    check_eq("ovf_sticky", ovf, 1);

    // Drain to one credit, then simultaneous launch and return of 2.
    for (int i = 0; i < 7; i++) push_word(word(200 + i));
    wait_drain();
    @(negedge clk);
    check_eq("cred_one", credit, 1);
    tick();
    src_vld = 1'b1;
    src_dat = word(300);
    crd_vld = 1'b1;
    crd_dat = 2'd2;
    @(negedge clk);
    check_eq("net_src_rdy", src_rdy, 1);
    exp_q.push_back(word(300));
    tick();
    src_vld = 1'b0;
    crd_vld = 1'b0;
    crd_dat = 2'd0;
    @(negedge clk);
    check_eq("net_launch_return", credit, 2);
    tick();
    wait_drain();

    // Reset mid-operation discards the in-flight word and reloads credits.
    pay_rdy = 1'b0;
    push_word(word(400));
    tick();
    check_eq("pre_reset_vld", pay_vld, 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("midrst_flags", {pay_vld, flow_vld, link_up, ovf, src_rdy}, 5'b0);
    check_eq("midrst_credit", credit, 4);
    tick();
    rst_n = 1'b1;
    pay_rdy = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aha_tlx_rev_tx.md
Name: aha_tlx_rev_tx

Overview:
- Transmit end of the TLX reverse channel; drives the 80-bit payload stream and 3-bit flow stream into the SoC's reverse data-link receiver.
- Accepts payload words from a local source, buffers them in a 2-entry skid FIFO and launches them only against returned link credits.
- Runs a link-training token sequence after reset, then sends heartbeat tokens while idle.
- Consumes credit returns on a 2-bit credit stream that matches the forward flow width.

Parameters:
- PAYLOAD_W, 80, payload word width.
- CREDIT_W, 4, credit counter width.
- INIT_CREDITS, 4, credit count loaded at reset (must be ≤ MAX_CREDITS).
- MAX_CREDITS, 8, saturation ceiling (must be ≤ 2^CREDIT_W-1).
- TRAIN_COUNT, 4, number of TRAIN tokens sent after reset (≥1).
- HB_PERIOD, 64, idle cycles before a heartbeat token; 0 disables heartbeats.

Ports:
- TLX_REV_CLK  in  1  clock
- TLX_REV_RESETn  in  1  reset, asynchronous assert, active-low
- SRC_TVALID  in  1  source word valid
- SRC_TREADY  out  1  source word accepted
- SRC_TDATA  in  PAYLOAD_W  source word
- TLX_REV_PAYLOAD_TVALID  out  1  payload valid
- TLX_REV_PAYLOAD_TREADY  in  1  payload ready
- TLX_REV_PAYLOAD_TDATA  out  PAYLOAD_W  payload
- TLX_REV_FLOW_TVALID  out  1  flow token valid
- TLX_REV_FLOW_TREADY  in  1  flow token ready
- TLX_REV_FLOW_TDATA  out  3  flow token
- TLX_CRD_TVALID  in  1  credit return valid
- TLX_CRD_TREADY  out  1  credit return ready
- TLX_CRD_TDATA  in  2  credits returned (0..3)
- LINK_UP  out  1  training complete
- CREDIT_COUNT  out  CREDIT_W  current credits
- CREDIT_OVF  out  1  sticky credit-overflow flag

Behaviour:
- Reset values: all TVALIDs 0; SRC_TREADY 0; TLX_CRD_TREADY 0; all TDATA 0; LINK_UP 0; CREDIT_OVF 0; CREDIT_COUNT = INIT_CREDITS; FSM = TRAIN; FIFO empty; heartbeat counter 0.
- FSM states:
  - TRAIN: send TRAIN_COUNT tokens of 3'b010, one per flow handshake, then go to DONE.
  - DONE: send one token 3'b011; on its handshake go to ACTIVE.
  - ACTIVE: terminal until reset; LINK_UP=1 (registered, rises the cycle after the DONE handshake).
- TLX_CRD_TREADY is 1 in every state after reset. Credits accumulate during training.
- SRC_TREADY = (FSM==ACTIVE) & FIFO not full. A source handshake writes the FIFO.
- Launch condition: FIFO head present & CREDIT_COUNT>0 (registered value) & (payload output register empty | TLX_REV_PAYLOAD_TREADY).
  - A launch loads the output register and sets TVALID.
  - Bypass: if the FIFO is empty, a word accepted at edge k is presented in cycle k+1 (latency 1).
- Payload TVALID/TDATA hold stable until handshake. A word is never withdrawn, including while credits are at 0.
- Credit arithmetic:
  - next = CREDIT_COUNT − launch + (TLX_CRD_TVALID ? TLX_CRD_TDATA : 0), computed at CREDIT_W+2 bits.
  - If next > MAX_CREDITS, clamp to MAX_CREDITS and set CREDIT_OVF. CREDIT_OVF clears only on reset.
  - A credit arriving while CREDIT_COUNT==0 allows a launch from the next cycle, not the same cycle.
  - Simultaneous launch and return net correctly; e.g. 1 − 1 + 2 = 2.
- Flow token handshake: once TLX_REV_FLOW_TVALID is asserted, TDATA holds until TREADY. No new token is generated while one is pending.
- Heartbeat (ACTIVE only, HB_PERIOD≠0):
  - Counter clears on any payload handshake or flow handshake, otherwise increments.
  - At HB_PERIOD−1 it raises token 3'b001 and holds at that value until the token handshakes.
- Payload and flow channels are independent; no ordering is implied between them.
- Reset asserted mid-operation: FIFO contents and the in-flight output word are discarded, credits reload to INIT_CREDITS, training restarts.
- Encodings 3'b000 and 3'b1xx are never driven.

Optional Feature:
- Macro: AHA_TLX_REV_TX_STATS_EN.
- Defined: adds outputs STAT_BEATS[31:0] (payload handshakes) and STAT_STALLS[31:0] (cycles with FIFO head present and CREDIT_COUNT==0). Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, flow TREADY=1 → tokens 010,010,010,010,011 on consecutive cycles; LINK_UP=1 one cycle after the last token; SRC_TREADY 0 until ACTIVE.
- ACTIVE, INIT_CREDITS=4, no returns, push 6 words with PAYLOAD_TREADY=1 → exactly 4 payload beats; CREDIT_COUNT=0; FIFO holds 2; SRC_TREADY=0.
- From that state, one credit beat TDATA=2 → next 2 words leave in order on the two following cycles; CREDIT_COUNT returns to 0.
- Hold PAYLOAD_TREADY=0 for 10 cycles with a word valid → TVALID and TDATA stable across all 10 cycles; exactly one beat on release.
- CREDIT_COUNT=7, return 3 → CREDIT_COUNT=8 (clamped); CREDIT_OVF=1 and stays set; simultaneous launch and return of 2 from count 1 → count 2.
- ACTIVE idle with HB_PERIOD=64 → token 001 after 64 idle cycles; a payload beat at cycle 40 defers it to 64 cycles after that beat; flow TREADY=0 holds 001 stable.
